// File: rtl/cmim_meas_ctrl.sv
// Measurement sequencer for two MIM-capacitor test channels: precharge, constant-current
// charge timed until the comparator trips, then discharge, with a held result handshake.
module cmim_meas_ctrl #(
  parameter int CNT_W       = 16,
  parameter int PRE_CYC     = 8,
  parameter int DIS_CYC     = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       start_i,
  input  logic [1:0]       cmp_i,
  output logic [1:0]       pre_sw_o,
  output logic [1:0]       isrc_en_o,
  output logic [1:0]       dis_sw_o,
  output logic             busy_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [CNT_W-1:0] res_data_o,
  output logic             res_chan_o,
  output logic             res_timeout_o
);

  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;
  localparam int TMR_MAX = (PRE_CYC > DIS_CYC) ? PRE_CYC : DIS_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  if (longint'(TIMEOUT_CYC) > longint'(CNT_MAX) || TIMEOUT_CYC < 1 ||
      PRE_CYC < 1 || DIS_CYC < 1) begin : g_param_check
    $error("cmim_meas_ctrl: TIMEOUT_CYC must fit in CNT_W bits and PRE_CYC/DIS_CYC must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    GAP  = 3'd2,
    CHG  = 3'd3,
    GAP2 = 3'd4,
    DIS  = 3'd5,
    RPT  = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         pend_q, pend_d;
  logic [1:0]         cmp_m, cmp_s;
  logic               prio_q;
  logic               chan_q, chan_d;
  logic               grant, gnt;
  logic [TMR_W-1:0]   tmr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               chg_done;
  logic [1:0]         chan_oh;
  logic [1:0]         pre_d, isrc_d, dis_d;
  logic               busy_d, valid_d;

  // Round robin: with both channels pending, the one not served last wins.
  assign grant    = (state_q == IDLE) && (pend_q != 2'b00);
  assign gnt      = (pend_q == 2'b11) ? prio_q : pend_q[1];
  assign chan_d   = grant ? gnt : chan_q;
  assign chg_done = (state_q == CHG) && (state_d == GAP2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (grant) state_d = PRE;
      PRE:  if (tmr_q == TMR_W'(PRE_CYC - 1)) state_d = GAP;
      GAP:  state_d = CHG;
      CHG:  if (cmp_s[chan_q] || (cnt_q == CNT_W'(TIMEOUT_CYC))) state_d = GAP2;
      GAP2: state_d = DIS;
      DIS:  if (tmr_q == TMR_W'(DIS_CYC - 1)) state_d = RPT;
      RPT:  if (res_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the next state so they are registered yet align with the state they belong to.
  always_comb begin
    chan_oh = chan_d ? 2'b10 : 2'b01;
    pre_d   = 2'b00;
    isrc_d  = 2'b00;
    dis_d   = 2'b00;
    case (state_d)
      PRE:     pre_d  = chan_oh;
      CHG:     isrc_d = chan_oh;
      DIS:     dis_d  = chan_oh;
      default: ;
    endcase
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == RPT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_sw_o    <= 2'b00;
      isrc_en_o   <= 2'b00;
      dis_sw_o    <= 2'b00;
      busy_o      <= 1'b0;
      res_valid_o <= 1'b0;
    end else begin
      pre_sw_o    <= pre_d;
      isrc_en_o   <= isrc_d;
      dis_sw_o    <= dis_d;
      busy_o      <= busy_d;
      res_valid_o <= valid_d;
    end
  end

  // A start coinciding with its own grant is absorbed by that grant.
  always_comb begin
    pend_d = pend_q | start_i;
    if (grant) pend_d[gnt] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_m  <= 2'b00;
      cmp_s  <= 2'b00;
      pend_q <= 2'b00;
      prio_q <= 1'b0;
      chan_q <= 1'b0;
    end else begin
      cmp_m  <= cmp_i;
      cmp_s  <= cmp_m;
      pend_q <= pend_d;
      chan_q <= chan_d;
      if (grant) prio_q <= ~gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= '0;
    end else if ((state_d == state_q) && ((state_q == PRE) || (state_q == DIS))) begin
      tmr_q <= tmr_q + TMR_W'(1);
    end else begin
      tmr_q <= '0;
    end
  end

  // The count starts at zero on the first charge cycle, so a comparator already high reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      res_data_o    <= '0;
      res_chan_o    <= 1'b0;
      res_timeout_o <= 1'b0;
    end else begin
      if (state_q == GAP) begin
        cnt_q <= '0;
      end else if ((state_q == CHG) && !chg_done) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (chg_done) begin
        res_data_o    <= cnt_q;
        res_chan_o    <= chan_q;
        res_timeout_o <= ~cmp_s[chan_q];
      end
    end
  end

  a_switch_excl: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({pre_sw_o, isrc_en_o, dis_sw_o}));

  a_result_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (res_valid_o && !res_ready_i) |=> ($stable(res_data_o) && $stable(res_chan_o) &&
                                       $stable(res_timeout_o) && res_valid_o));

endmodule

// File: tb/tb_cmim_meas_ctrl.sv
// Directed bench for cmim_meas_ctrl: timing of switch phases, round robin, timeout,
// stuck-high comparator, result hold under backpressure and reset mid-charge.
module tb_cmim_meas_ctrl;

  localparam int CNT_W   = 16;
  localparam int PRE_CYC = 8;
  localparam int DIS_CYC = 16;
  localparam int TO_CYC  = 50;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       start_i, cmp_i;
  logic [1:0]       pre_sw, isrc_en, dis_sw;
  logic             busy, res_valid, res_ready, res_chan, res_timeout;
  logic [CNT_W-1:0] res_data;

  logic [1:0]       start_t, cmp_t;
  logic [1:0]       pre_sw_t, isrc_en_t, dis_sw_t;
  logic             busy_t, res_valid_t, res_ready_t, res_chan_t, res_timeout_t;
  logic [CNT_W-1:0] res_data_t;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cmim_meas_ctrl #(.CNT_W(CNT_W), .PRE_CYC(PRE_CYC), .DIS_CYC(DIS_CYC), .TIMEOUT_CYC(65535)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .cmp_i(cmp_i),
    .pre_sw_o(pre_sw), .isrc_en_o(isrc_en), .dis_sw_o(dis_sw), .busy_o(busy),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
    .res_chan_o(res_chan), .res_timeout_o(res_timeout)
  );

  cmim_meas_ctrl #(.CNT_W(CNT_W), .PRE_CYC(PRE_CYC), .DIS_CYC(DIS_CYC), .TIMEOUT_CYC(TO_CYC)) dut_t (
    .clk(clk), .rst_n(rst_n), .start_i(start_t), .cmp_i(cmp_t),
    .pre_sw_o(pre_sw_t), .isrc_en_o(isrc_en_t), .dis_sw_o(dis_sw_t), .busy_o(busy_t),
    .res_valid_o(res_valid_t), .res_ready_i(res_ready_t), .res_data_o(res_data_t),
    .res_chan_o(res_chan_t), .res_timeout_o(res_timeout_t)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic [1:0] start, input logic [1:0] cmp, input logic ready);
    start_i   = start;
    cmp_i     = cmp;
    res_ready = ready;
  endtask

  task automatic nextCycle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitValid(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (res_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      nextCycle(1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   width;
    int   dwidth;
    int   n;
    logic ok;

    rst_n = 1'b0;
    applyStimulus(2'b00, 2'b00, 1'b0);
    start_t = 2'b00; cmp_t = 2'b00; res_ready_t = 1'b0;
    nextCycle(2);
    checkOutput("rst_switches", 32'({pre_sw, isrc_en, dis_sw}), 0);
    checkOutput("rst_status", 32'({busy, res_valid, res_chan, res_timeout}), 0);
    checkOutput("rst_data", 32'(res_data), 0);
    rst_n = 1'b1;
    nextCycle(2);
    checkOutput("idle_busy", 32'(busy), 0);

    // Channel 0 with comparator trip; charge cycle index = count.
    $display("[TB] single channel 0 measurement");
    applyStimulus(2'b01, 2'b00, 1'b0);
    nextCycle(1);
    applyStimulus(2'b00, 2'b00, 1'b0);
    checkOutput("t1_pend_no_pre_yet", 32'(pre_sw), 0);
    checkOutput("t1_busy_idle", 32'(busy), 0);
    nextCycle(1);
    checkOutput("t1_pre_on", 32'(pre_sw), 1);
    checkOutput("t1_busy_on", 32'(busy), 1);
    width = 0;
    while (pre_sw == 2'b01 && width < 100) begin
      width++;
      nextCycle(1);
    end
    checkOutput("t1_pre_width", width, PRE_CYC);
    checkOutput("t1_gap_all_off", 32'({pre_sw, isrc_en, dis_sw}), 0);
    nextCycle(1);
    checkOutput("t1_isrc_on", 32'(isrc_en), 1);
    width = 1;
    for (int i = 0; i < 99; i++) begin
      nextCycle(1);
      if (isrc_en == 2'b01) width++;
    end
    // Sampled by the synchronizer on the 100th edge after charge start: visible at count 101.
    applyStimulus(2'b00, 2'b01, 1'b0);
    nextCycle(1);
    while (isrc_en == 2'b01 && width < 300) begin
      width++;
      nextCycle(1);
    end
    checkOutput("t1_chg_width", width, 102);
    checkOutput("t1_gap2_all_off", 32'({pre_sw, isrc_en, dis_sw}), 0);
    applyStimulus(2'b00, 2'b00, 1'b0);
    nextCycle(1);
    width = 0;
    while (dis_sw == 2'b01 && width < 100) begin
      width++;
      nextCycle(1);
    end
    checkOutput("t1_dis_width", width, DIS_CYC);
    checkOutput("t1_valid", 32'(res_valid), 1);
    checkOutput("t1_data", 32'(res_data), 101);
    checkOutput("t1_chan", 32'(res_chan), 0);
    checkOutput("t1_timeout", 32'(res_timeout), 0);

    // Backpressure: result must stay put while ready is low.
    for (int i = 0; i < 20; i++) begin
      nextCycle(1);
      checkOutput("t5_valid_hold", 32'(res_valid), 1);
      checkOutput("t5_data_hold", 32'(res_data), 101);
    end
    applyStimulus(2'b00, 2'b00, 1'b1);
    nextCycle(1);
    applyStimulus(2'b00, 2'b00, 1'b0);
    checkOutput("t5_valid_drop", 32'(res_valid), 0);
    checkOutput("t5_busy_drop", 32'(busy), 0);
    checkOutput("t5_data_kept", 32'(res_data), 101);

    rst_n = 1'b0;
    nextCycle(1);
    rst_n = 1'b1;
    nextCycle(1);

    // Both channels at once with comparators stuck high; ready held high.
    $display("[TB] round robin with stuck-high comparators");
    applyStimulus(2'b00, 2'b11, 1'b1);
    nextCycle(3);
    applyStimulus(2'b11, 2'b11, 1'b1);
    nextCycle(1);
    applyStimulus(2'b00, 2'b11, 1'b1);
    waitValid(ok);
    checkOutput("t2_first_reached", 32'(ok), 1);
    checkOutput("t2_first_chan", 32'(res_chan), 0);
    checkOutput("t4_ch0_stuck_zero", 32'(res_data), 0);
    nextCycle(1);
    checkOutput("t2_idle_gap_busy", 32'(busy), 0);
    nextCycle(1);
    checkOutput("t2_second_pre", 32'(pre_sw), 2);
    checkOutput("t2_second_busy", 32'(busy), 1);
    waitValid(ok);
    checkOutput("t2_second_reached", 32'(ok), 1);
    checkOutput("t2_second_chan", 32'(res_chan), 1);
    checkOutput("t4_ch1_stuck_zero", 32'(res_data), 0);
    checkOutput("t4_ch1_timeout", 32'(res_timeout), 0);
    nextCycle(1);
    checkOutput("t2_done_idle", 32'(busy), 0);
    nextCycle(1);
    checkOutput("t2_stays_idle", 32'(busy), 0);
    applyStimulus(2'b11, 2'b11, 1'b1);
    nextCycle(1);
    applyStimulus(2'b00, 2'b11, 1'b1);
    nextCycle(1);
    checkOutput("t2_rr_ch0_pre", 32'(pre_sw), 1);
    waitValid(ok);
    checkOutput("t2_rr_ch0_chan", 32'(res_chan), 0);
    nextCycle(2);
    checkOutput("t2_rr_ch1_pre", 32'(pre_sw), 2);
    waitValid(ok);
    checkOutput("t2_rr_ch1_chan", 32'(res_chan), 1);
    nextCycle(1);
    applyStimulus(2'b00, 2'b00, 1'b0);

    // Timeout instance: comparator never trips.
    $display("[TB] timeout run");
    start_t = 2'b01;
    nextCycle(1);
    start_t = 2'b00;
    width = 0; dwidth = 0; n = 0;
    while (res_valid_t !== 1'b1 && n < 300) begin
      if (isrc_en_t == 2'b01) width++;
      if (dis_sw_t == 2'b01) dwidth++;
      nextCycle(1);
      n++;
    end
    checkOutput("t3_reached", 32'(res_valid_t), 1);
    checkOutput("t3_data", 32'(res_data_t), TO_CYC);
    checkOutput("t3_timeout", 32'(res_timeout_t), 1);
    checkOutput("t3_chan", 32'(res_chan_t), 0);
    checkOutput("t3_chg_width", width, TO_CYC + 1);
    checkOutput("t3_dis_width", dwidth, DIS_CYC);
    res_ready_t = 1'b1;
    nextCycle(1);
    res_ready_t = 1'b0;
    checkOutput("t3_released", 32'(res_valid_t), 0);

    // Reset during charge with channel 1 pending.
    $display("[TB] reset mid-charge");
    applyStimulus(2'b01, 2'b00, 1'b0);
    nextCycle(1);
    applyStimulus(2'b00, 2'b00, 1'b0);
    n = 0;
    while (isrc_en != 2'b01 && n < 50) begin
      nextCycle(1);
      n++;
    end
    checkOutput("t6_chg_reached", 32'(isrc_en), 1);
    applyStimulus(2'b10, 2'b00, 1'b0);
    nextCycle(1);
    applyStimulus(2'b00, 2'b00, 1'b0);
    nextCycle(5);
    checkOutput("t6_still_charging", 32'(isrc_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_isrc_async_off", 32'(isrc_en), 0);
    checkOutput("t6_all_switches_off", 32'({pre_sw, dis_sw}), 0);
    checkOutput("t6_status_off", 32'({busy, res_valid, res_chan, res_timeout}), 0);
    checkOutput("t6_data_cleared", 32'(res_data), 0);
    nextCycle(1);
    rst_n = 1'b1;
    nextCycle(4);
    checkOutput("t6_pend_cleared_busy", 32'(busy), 0);
    checkOutput("t6_pend_cleared_pre", 32'(pre_sw), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
